// File: rtl/reg_wb_sched_pkg.sv
// ---------------------------------------------------------------------------
// reg_wb_sched_pkg
// Shared definitions for the register-file write-back scheduler:
//   REG_ADDR_W / REG_DATA_W : register file address and data widths
//   R15_ADDR                : index of the dedicated high-word register
//   mdu_result_t            : one buffered multiply/divide result
//   reg_onehot()            : register index -> one-hot 16-bit mask
// ---------------------------------------------------------------------------
package reg_wb_sched_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int REG_DATA_W = 16;
    localparam logic [REG_ADDR_W-1:0] R15_ADDR = 4'hF;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dst;
        logic [REG_DATA_W-1:0] lo;
        logic [REG_DATA_W-1:0] hi;
        logic                  hi_en;
    } mdu_result_t;

    function automatic logic [15:0] reg_onehot(input logic [REG_ADDR_W-1:0] idx);
        return 16'h0001 << idx;
    endfunction

endpackage

// File: rtl/reg_wb_sched_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
// Tracks registers that still have an MDU write in flight and produces the
// decode stall.
//   clk, rst        : clock, synchronous active-low reset
//   iss_*           : MDU issue request from decode (accepted when not stalled)
//   src1/src2/dec_* : operands / destination of the instruction in decode
//   cmt_*           : commit of the buffered MDU result this cycle
//   starve_stall    : starvation stall from the write-back buffer
//   stall           : decode stall (hazards | full | starvation)
//   pend_mask       : pending-write bit per register
// ---------------------------------------------------------------------------
module reg_scoreboard
    import reg_wb_sched_pkg::*;
#(
    parameter int MAX_OUT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_dst,
    input  logic                  iss_hi_en,
    input  logic [REG_ADDR_W-1:0] src1_addr,
    input  logic [REG_ADDR_W-1:0] src2_addr,
    input  logic [REG_ADDR_W-1:0] dec_dst,
    input  logic                  dec_uses_r15,
    input  logic                  cmt,
    input  logic [REG_ADDR_W-1:0] cmt_dst,
    input  logic                  cmt_hi_en,
    input  logic                  starve_stall,
    output logic                  stall,
    output logic [15:0]           pend_mask
);

    localparam logic [1:0] MAX_OUT_C = 2'(MAX_OUT);

    logic [15:0] pend_mask_d, pend_mask_q;
    logic [1:0]  count_d, count_q;
    logic        iss_acc;

    always_comb begin
        stall = pend_mask_q[src1_addr]
              | pend_mask_q[src2_addr]
              | pend_mask_q[dec_dst]
              | (dec_uses_r15 & pend_mask_q[R15_ADDR])
              | (iss_valid & (count_q == MAX_OUT_C))
              | starve_stall;

        iss_acc = iss_valid & ~stall;

        // Clear first, then set, so an issue to a register committing in the
        // same cycle keeps its pending bit.
        pend_mask_d = pend_mask_q;
        if (cmt) begin
            pend_mask_d = pend_mask_d & ~reg_onehot(cmt_dst);
            if (cmt_hi_en) begin
                pend_mask_d[R15_ADDR] = 1'b0;
            end
        end
        if (iss_acc) begin
            pend_mask_d = pend_mask_d | reg_onehot(iss_dst);
            if (iss_hi_en) begin
                pend_mask_d[R15_ADDR] = 1'b1;
            end
        end

        // Guards keep the 2-bit count from wrapping even on protocol errors
        // (a commit with nothing outstanding leaves it at zero).
        count_d = count_q;
        if (iss_acc && !cmt) begin
            if (count_q != 2'd3) begin
                count_d = count_q + 2'd1;
            end
        end else if (cmt && !iss_acc) begin
            if (count_q != 2'd0) begin
                count_d = count_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_mask_q <= '0;
            count_q     <= '0;
        end else begin
            pend_mask_q <= pend_mask_d;
            count_q     <= count_d;
        end
    end

    assign pend_mask = pend_mask_q;

endmodule

// File: rtl/reg_wb_sched.sv
// ---------------------------------------------------------------------------
// reg_wb_sched
// Write-back scheduler in front of the 16x16 register file. The pipeline
// write-back always owns the general and R15 write ports; a single buffered
// MDU result is written (low word + optional R15 high word, atomically) in a
// cycle where every port it needs is free.
//   clk, rst                : clock, synchronous active-low reset
//   wb_*                    : pipeline write-back (never stalled)
//   iss_*, src*, dec_*      : decode-side issue and hazard inputs
//   mdu_*                   : MDU result handshake (mdu_ready = buffer empty)
//   reg_WE/W_addr/W_data    : register file general write port
//   R15_WE/W_R15            : register file R15 write port
//   stall, starve_stall     : decode stall and its starvation component
//   pend_mask               : scoreboard contents (debug)
// ---------------------------------------------------------------------------
module reg_wb_sched
    import reg_wb_sched_pkg::*;
#(
    parameter int MAX_OUT    = 2,
    parameter int STARVE_LIM = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [REG_DATA_W-1:0] wb_data,
    input  logic                  wb_r15_we,
    input  logic [REG_DATA_W-1:0] wb_r15_data,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_dst,
    input  logic                  iss_hi_en,
    input  logic [REG_ADDR_W-1:0] src1_addr,
    input  logic [REG_ADDR_W-1:0] src2_addr,
    input  logic [REG_ADDR_W-1:0] dec_dst,
    input  logic                  dec_uses_r15,
    input  logic                  mdu_valid,
    input  logic [REG_ADDR_W-1:0] mdu_dst,
    input  logic [REG_DATA_W-1:0] mdu_lo,
    input  logic [REG_DATA_W-1:0] mdu_hi,
    input  logic                  mdu_hi_en,
    output logic                  mdu_ready,
    output logic                  reg_WE,
    output logic [REG_ADDR_W-1:0] W_addr,
    output logic [REG_DATA_W-1:0] W_data,
    output logic                  R15_WE,
    output logic [REG_DATA_W-1:0] W_R15,
    output logic                  stall,
    output logic                  starve_stall,
    output logic [15:0]           pend_mask
);

    localparam int STV_W = $clog2(STARVE_LIM + 1);
    localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIM);

    mdu_result_t       buf_d, buf_q;
    logic              buf_valid_d, buf_valid_q;
    logic [STV_W-1:0]  starve_cnt_d, starve_cnt_q;
    logic              commit;
    logic              accept;

    always_comb begin
        // Commit is suppressed in a reset cycle so a discarded result never
        // reaches the register file.
        commit = rst & buf_valid_q & ~wb_we & (~buf_q.hi_en | ~wb_r15_we);
        accept = mdu_valid & ~buf_valid_q;

        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        if (commit) begin
            buf_valid_d = 1'b0;
        end
        if (accept) begin
            buf_valid_d = 1'b1;
            buf_d       = '{dst: mdu_dst, lo: mdu_lo, hi: mdu_hi, hi_en: mdu_hi_en};
        end

        starve_cnt_d = starve_cnt_q;
        if (commit) begin
            starve_cnt_d = '0;
        end else if (buf_valid_q && (starve_cnt_q != STV_MAX)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end

        starve_stall = (starve_cnt_q == STV_MAX);
        mdu_ready    = ~buf_valid_q;

        // Pipeline values pass through by default; a commit only happens when
        // the pipeline is not using the ports it needs.
        reg_WE = wb_we;
        W_addr = wb_addr;
        W_data = wb_data;
        R15_WE = wb_r15_we;
        W_R15  = wb_r15_data;
        if (commit) begin
            reg_WE = 1'b1;
            W_addr = buf_q.dst;
            W_data = buf_q.lo;
            if (buf_q.hi_en) begin
                R15_WE = 1'b1;
                W_R15  = buf_q.hi;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            buf_q        <= '0;
            buf_valid_q  <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            buf_q        <= buf_d;
            buf_valid_q  <= buf_valid_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    reg_scoreboard #(
        .MAX_OUT (MAX_OUT)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .iss_valid    (iss_valid),
        .iss_dst      (iss_dst),
        .iss_hi_en    (iss_hi_en),
        .src1_addr    (src1_addr),
        .src2_addr    (src2_addr),
        .dec_dst      (dec_dst),
        .dec_uses_r15 (dec_uses_r15),
        .cmt          (commit),
        .cmt_dst      (buf_q.dst),
        .cmt_hi_en    (buf_q.hi_en),
        .starve_stall (starve_stall),
        .stall        (stall),
        .pend_mask    (pend_mask)
    );

endmodule

// File: tb/tb_reg_wb_sched.sv
// ---------------------------------------------------------------------------
// tb_reg_wb_sched
// Directed bench for reg_wb_sched. A behavioural model tracks the buffered
// result, pending registers, in-flight count and wait time, and every falling
// edge the DUT outputs are compared against it. Directed sequences add
// hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_reg_wb_sched;

    localparam int MAX_OUT    = 2;
    localparam int STARVE_LIM = 8;

    logic        clk;
    logic        rst;
    logic        wb_we;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        wb_r15_we;
    logic [15:0] wb_r15_data;
    logic        iss_valid;
    logic [3:0]  iss_dst;
    logic        iss_hi_en;
    logic [3:0]  src1_addr;
    logic [3:0]  src2_addr;
    logic [3:0]  dec_dst;
    logic        dec_uses_r15;
    logic        mdu_valid;
    logic [3:0]  mdu_dst;
    logic [15:0] mdu_lo;
    logic [15:0] mdu_hi;
    logic        mdu_hi_en;
    logic        mdu_ready;
    logic        reg_WE;
    logic [3:0]  W_addr;
    logic [15:0] W_data;
    logic        R15_WE;
    logic [15:0] W_R15;
    logic        stall;
    logic        starve_stall;
    logic [15:0] pend_mask;

    int n_vec = 0;
    int n_err = 0;

    reg_wb_sched #(
        .MAX_OUT    (MAX_OUT),
        .STARVE_LIM (STARVE_LIM)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_we        (wb_we),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .wb_r15_we    (wb_r15_we),
        .wb_r15_data  (wb_r15_data),
        .iss_valid    (iss_valid),
        .iss_dst      (iss_dst),
        .iss_hi_en    (iss_hi_en),
        .src1_addr    (src1_addr),
        .src2_addr    (src2_addr),
        .dec_dst      (dec_dst),
        .dec_uses_r15 (dec_uses_r15),
        .mdu_valid    (mdu_valid),
        .mdu_dst      (mdu_dst),
        .mdu_lo       (mdu_lo),
        .mdu_hi       (mdu_hi),
        .mdu_hi_en    (mdu_hi_en),
        .mdu_ready    (mdu_ready),
        .reg_WE       (reg_WE),
        .W_addr       (W_addr),
        .W_data       (W_data),
        .R15_WE       (R15_WE),
        .W_R15        (W_R15),
        .stall        (stall),
        .starve_stall (starve_stall),
        .pend_mask    (pend_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: the buffered result, which registers await an MDU write,
    // how many MDU ops are in flight, and how long the buffer has waited.
    bit        m_bv;
    bit [3:0]  m_dst;
    bit [15:0] m_lo;
    bit [15:0] m_hi;
    bit        m_hien;
    bit [15:0] m_pend;
    int        m_out;
    int        m_wait;

    initial begin
        m_bv = 0; m_dst = 0; m_lo = 0; m_hi = 0; m_hien = 0;
        m_pend = 0; m_out = 0; m_wait = 0;
    end

    always @(negedge clk) begin : model_cmp
        bit        cmt, acc, iss, e_stall, e_starve, e_we, e_r15we;
        bit [3:0]  e_addr;
        bit [15:0] e_data, e_r15;

        e_starve = (m_wait >= STARVE_LIM);
        cmt = rst && m_bv && !wb_we && !(m_hien && wb_r15_we);
        e_stall = m_pend[src1_addr] || m_pend[src2_addr] || m_pend[dec_dst]
                  || (dec_uses_r15 && m_pend[15])
                  || (iss_valid && (m_out == MAX_OUT)) || e_starve;

        if (cmt) begin
            e_we = 1; e_addr = m_dst; e_data = m_lo;
            e_r15we = m_hien || wb_r15_we;
            e_r15   = m_hien ? m_hi : wb_r15_data;
        end else begin
            e_we = wb_we; e_addr = wb_addr; e_data = wb_data;
            e_r15we = wb_r15_we; e_r15 = wb_r15_data;
        end

        chk("mdl_mdu_ready", 32'(mdu_ready), 32'(!m_bv));
        chk("mdl_stall", 32'(stall), 32'(e_stall));
        chk("mdl_starve_stall", 32'(starve_stall), 32'(e_starve));
        chk("mdl_pend_mask", 32'(pend_mask), 32'(m_pend));
        chk("mdl_reg_WE", 32'(reg_WE), 32'(e_we));
        chk("mdl_W_addr", 32'(W_addr), 32'(e_addr));
        chk("mdl_W_data", 32'(W_data), 32'(e_data));
        chk("mdl_R15_WE", 32'(R15_WE), 32'(e_r15we));
        chk("mdl_W_R15", 32'(W_R15), 32'(e_r15));

        if (!rst) begin
            m_bv = 0; m_dst = 0; m_lo = 0; m_hi = 0; m_hien = 0;
            m_pend = 0; m_out = 0; m_wait = 0;
        end else begin
            acc = mdu_valid && !m_bv;
            iss = iss_valid && !e_stall;
            if (cmt) begin
                m_pend[m_dst] = 0;
                if (m_hien) m_pend[15] = 0;
            end
            if (iss) begin
                m_pend[iss_dst] = 1;
                if (iss_hi_en) m_pend[15] = 1;
            end
            if (iss && !cmt) m_out = m_out + 1;
            else if (cmt && !iss && m_out > 0) m_out = m_out - 1;
            if (cmt) m_wait = 0;
            else if (m_bv && m_wait < STARVE_LIM) m_wait = m_wait + 1;
            if (cmt) m_bv = 0;
            if (acc) begin
                m_bv = 1; m_dst = mdu_dst; m_lo = mdu_lo; m_hi = mdu_hi; m_hien = mdu_hi_en;
            end
        end
    end

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 0; wb_we = 0; wb_addr = 0; wb_data = 0; wb_r15_we = 0; wb_r15_data = 0;
        iss_valid = 0; iss_dst = 0; iss_hi_en = 0; src1_addr = 0; src2_addr = 0;
        dec_dst = 0; dec_uses_r15 = 0; mdu_valid = 0; mdu_dst = 0; mdu_lo = 0;
        mdu_hi = 0; mdu_hi_en = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;

        // 1: idle after reset
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("t1_ready", 32'(mdu_ready), 1);
            chk("t1_stall", 32'(stall), 0);
            chk("t1_pend", 32'(pend_mask), 0);
            chk("t1_reg_WE", 32'(reg_WE), 0);
            chk("t1_R15_WE", 32'(R15_WE), 0);
            nxt();
        end

        // 2: issue dst 3 with high word, RAW stall, commit both ports
        iss_valid = 1; iss_dst = 3; iss_hi_en = 1;
        mid(); chk("t2_issue_nostall", 32'(stall), 0); nxt();
        iss_valid = 0; iss_hi_en = 0; src1_addr = 3;
        mdu_valid = 1; mdu_dst = 3; mdu_lo = 16'h1234; mdu_hi = 16'h0001; mdu_hi_en = 1;
        mid();
        chk("t2_pend", 32'(pend_mask), 32'h8008);
        chk("t2_raw_stall", 32'(stall), 1);
        chk("t2_ready", 32'(mdu_ready), 1);
        nxt();
        mdu_valid = 0;
        mid();
        chk("t2_reg_WE", 32'(reg_WE), 1);
        chk("t2_W_addr", 32'(W_addr), 3);
        chk("t2_W_data", 32'(W_data), 32'h1234);
        chk("t2_R15_WE", 32'(R15_WE), 1);
        chk("t2_W_R15", 32'(W_R15), 32'h0001);
        nxt();
        mid();
        chk("t2_pend_clr", 32'(pend_mask), 0);
        chk("t2_stall_clr", 32'(stall), 0);
        chk("t2_idle_WE", 32'(reg_WE), 0);
        nxt();
        src1_addr = 0;

        // 3: R15 port busy blocks the whole commit
        iss_valid = 1; iss_dst = 5; iss_hi_en = 1;
        nxt();
        iss_valid = 0; iss_hi_en = 0;
        mdu_valid = 1; mdu_dst = 5; mdu_lo = 16'h5555; mdu_hi = 16'hAAAA; mdu_hi_en = 1;
        wb_r15_we = 1; wb_r15_data = 16'h0F0F;
        nxt();
        mdu_valid = 0;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("t3_no_split_WE", 32'(reg_WE), 0);
            chk("t3_pipe_R15_WE", 32'(R15_WE), 1);
            chk("t3_pipe_W_R15", 32'(W_R15), 32'h0F0F);
            nxt();
        end
        wb_r15_we = 0;
        mid();
        chk("t3_reg_WE", 32'(reg_WE), 1);
        chk("t3_W_addr", 32'(W_addr), 5);
        chk("t3_W_data", 32'(W_data), 32'h5555);
        chk("t3_R15_WE", 32'(R15_WE), 1);
        chk("t3_W_R15", 32'(W_R15), 32'hAAAA);
        nxt();
        mid(); chk("t3_pend_clr", 32'(pend_mask), 0); nxt();

        // 4: starvation under continuous pipeline write-back
        iss_valid = 1; iss_dst = 7; iss_hi_en = 0;
        nxt();
        iss_valid = 0;
        mdu_valid = 1; mdu_dst = 7; mdu_lo = 16'h7777; mdu_hi = 16'h0; mdu_hi_en = 0;
        wb_we = 1; wb_addr = 9; wb_data = 16'h9999;
        nxt();
        mdu_valid = 0;
        for (int j = 1; j <= 10; j++) begin
            mid();
            chk("t4_starve", 32'(starve_stall), 32'(j >= 9));
            chk("t4_stall", 32'(stall), 32'(j >= 9));
            chk("t4_pipe_addr", 32'(W_addr), 9);
            nxt();
        end
        wb_we = 0;
        mid();
        chk("t4_commit_WE", 32'(reg_WE), 1);
        chk("t4_commit_addr", 32'(W_addr), 7);
        chk("t4_commit_data", 32'(W_data), 32'h7777);
        chk("t4_commit_R15_WE", 32'(R15_WE), 0);
        nxt();
        mid();
        chk("t4_starve_clr", 32'(starve_stall), 0);
        chk("t4_stall_clr", 32'(stall), 0);
        nxt();

        // 5: outstanding limit
        iss_valid = 1; iss_dst = 1;
        nxt();
        iss_dst = 2;
        nxt();
        iss_dst = 4;
        mid();
        chk("t5_full_stall", 32'(stall), 1);
        chk("t5_pend", 32'(pend_mask), 32'h0006);
        nxt();
        mdu_valid = 1; mdu_dst = 1; mdu_lo = 16'h1111; mdu_hi_en = 0;
        mid(); chk("t5_still_full", 32'(stall), 1); nxt();
        mdu_valid = 0;
        mid();
        chk("t5_commit_WE", 32'(reg_WE), 1);
        chk("t5_commit_addr", 32'(W_addr), 1);
        chk("t5_commit_stall", 32'(stall), 1);
        nxt();
        mid(); chk("t5_stall_drop", 32'(stall), 0); nxt();
        iss_valid = 0;
        mid(); chk("t5_pend_after", 32'(pend_mask), 32'h0014); nxt();

        // drain dst 2 and dst 4
        mdu_valid = 1; mdu_dst = 2; mdu_lo = 16'h2222;
        nxt();
        mdu_valid = 0;
        nxt();
        mdu_valid = 1; mdu_dst = 4; mdu_lo = 16'h4444;
        nxt();
        mdu_valid = 0;
        nxt();
        mid(); chk("t6_drained", 32'(pend_mask), 0); nxt();

        // 6: reset with a full buffer
        iss_valid = 1; iss_dst = 1;
        nxt();
        iss_dst = 2;
        nxt();
        iss_valid = 0;
        wb_we = 1; wb_addr = 4'hA; wb_data = 16'hAAAA;
        mdu_valid = 1; mdu_dst = 1; mdu_lo = 16'hBEEF;
        nxt();
        mdu_valid = 0;
        mid();
        chk("t6_buf_full", 32'(mdu_ready), 0);
        chk("t6_pend", 32'(pend_mask), 32'h0006);
        nxt();
        rst = 0; wb_we = 0;
        mid();
        chk("t6_rst_no_WE", 32'(reg_WE), 0);
        chk("t6_rst_no_R15", 32'(R15_WE), 0);
        nxt();
        rst = 1;
        mid();
        chk("t6_ready", 32'(mdu_ready), 1);
        chk("t6_pend_clr", 32'(pend_mask), 0);
        chk("t6_no_WE", 32'(reg_WE), 0);
        chk("t6_stall", 32'(stall), 0);
        nxt();
        iss_valid = 1; iss_dst = 8;
        mid(); chk("t6_cnt_reset_a", 32'(stall), 0); nxt();
        iss_dst = 9;
        mid(); chk("t6_cnt_reset_b", 32'(stall), 0); nxt();
        iss_valid = 0;
        repeat (2) nxt();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
